// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start, 1..DBIT_MAX data bits LSB first, optional parity, 1/1.5/2 stop bits.
// Optional line-break support is compiled in with `define UART_TX_BREAK_EN (adds the tx_break input).
module uart_tx_cfg #(
  parameter int DBIT_MAX = 8,
  parameter int OS       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_tick,
  input  logic                        tx_start,
`ifdef UART_TX_BREAK_EN
  input  logic                        tx_break,
`endif
  input  logic [DBIT_MAX-1:0]         tx_din,
  input  logic [$clog2(DBIT_MAX)-1:0] cfg_dlen,
  input  logic [1:0]                  cfg_parity,
  input  logic [1:0]                  cfg_stop,
  output logic                        tx,
  output logic                        tx_busy,
  output logic                        tx_done
);

  localparam int DLW = $clog2(DBIT_MAX);
  localparam int TW  = $clog2(2 * OS);
  localparam logic [TW-1:0] T_BIT_LAST  = TW'(OS - 1);
  localparam logic [TW-1:0] T_HALF_LAST = TW'(OS + OS / 2 - 1);
  localparam logic [TW-1:0] T_TWO_LAST  = TW'(2 * OS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [DLW-1:0]        bit_q, bit_d;
  logic [DBIT_MAX-1:0]   shreg_q, shreg_d;
  logic [DLW-1:0]        dlen_q, dlen_d;
  logic [1:0]            par_q, par_d;
  logic [1:0]            stop_q, stop_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  accept_s;
  logic                  par_en_s;
  logic [TW-1:0]         stop_last_s;
  logic [DBIT_MAX-1:0]   shreg_shift_s;

  // Parity over the first dlen+1 bits only; odd parity starts the fold at 1.
  function automatic logic parity_f(input logic [DBIT_MAX-1:0] data,
                                    input logic [DLW-1:0] dlen,
                                    input logic odd);
    logic acc;
    logic in_s;
    acc = odd;
    for (int i = 0; i < DBIT_MAX; i++) begin
      in_s = (i <= int'(dlen));
      acc  = acc ^ (data[i] & in_s);
    end
    return acc;
  endfunction

  // Side decodes: acceptance qualifier, parity enable and the last stop tick index.
  always_comb begin
`ifdef UART_TX_BREAK_EN
    accept_s = tx_start & ~tx_break;
`else
    accept_s = tx_start;
`endif
    par_en_s      = (par_q == 2'b01) || (par_q == 2'b10);
    shreg_shift_s = shreg_q >> 1;
    case (stop_q)
      2'b00:   stop_last_s = T_BIT_LAST;
      2'b01:   stop_last_s = T_HALF_LAST;
      default: stop_last_s = T_TWO_LAST;
    endcase
  end

  // Next-state and next-output logic; without s_tick every counter holds.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    dlen_d    = dlen_q;
    par_d     = par_q;
    stop_d    = stop_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
`ifdef UART_TX_BREAK_EN
        if (tx_break) begin
          tx_d   = 1'b0;
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
`endif
        if (accept_s) begin
          shreg_d   = tx_din;
          dlen_d    = cfg_dlen;
          par_d     = cfg_parity;
          stop_d    = cfg_stop;
          par_bit_d = parity_f(tx_din, cfg_dlen, cfg_parity == 2'b10);
          tick_d    = {TW{1'b0}};
          bit_d     = {DLW{1'b0}};
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (s_tick && (tick_q == T_BIT_LAST)) begin
          tick_d  = {TW{1'b0}};
          tx_d    = shreg_q[0];
          state_d = DATA;
        end else if (s_tick) begin
          tick_d = tick_q + TW'(1);
        end else begin
          tick_d = tick_q;
        end
      end
      DATA: begin
        if (s_tick && (tick_q == T_BIT_LAST)) begin
          tick_d = {TW{1'b0}};
          if (bit_q == dlen_q) begin
            tx_d    = par_en_s ? par_bit_q : 1'b1;
            state_d = par_en_s ? PARITY : STOP;
          end else begin
            bit_d   = bit_q + DLW'(1);
            shreg_d = shreg_shift_s;
            tx_d    = shreg_shift_s[0];
          end
        end else if (s_tick) begin
          tick_d = tick_q + TW'(1);
        end else begin
          tick_d = tick_q;
        end
      end
      PARITY: begin
        if (s_tick && (tick_q == T_BIT_LAST)) begin
          tick_d  = {TW{1'b0}};
          tx_d    = 1'b1;
          state_d = STOP;
        end else if (s_tick) begin
          tick_d = tick_q + TW'(1);
        end else begin
          tick_d = tick_q;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (s_tick && (tick_q == stop_last_s)) begin
          tick_d  = {TW{1'b0}};
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (s_tick) begin
          tick_d = tick_q + TW'(1);
        end else begin
          tick_d = tick_q;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tick_q    <= {TW{1'b0}};
      bit_q     <= {DLW{1'b0}};
      shreg_q   <= {DBIT_MAX{1'b0}};
      dlen_q    <= {DLW{1'b0}};
      par_q     <= 2'b00;
      stop_q    <= 2'b00;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      dlen_q    <= dlen_d;
      par_q     <= par_d;
      stop_q    <= stop_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
